// File: rtl/im_program_loader_if.sv
// -----------------------------------------------------------------------------
// im_program_loader_if
// Purpose: groups the byte stream, IM write port, processor control and status
//          signals of the program loader.
// Modports:
//   slave  - the loader: consumes the stream/abort/clear/stop, drives the rest
//   master - the feeder side: drives the stream/abort/clear/stop, observes rest
// Signals:
//   in_valid/in_byte/in_ready        byte stream handshake
//   abort_i, err_clr_i                abort of load/run, error clear
//   im_w_en/im_w_addr/im_w_data       instruction memory write port
//   cpu_rst_o, start_o, stop_i        processor reset, start pulse, stop flag
//   busy_o, done_o, err_o             status
//   words_loaded_o                    words written in the current load
// -----------------------------------------------------------------------------
interface im_program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_byte;
    logic                  in_ready;
    logic                  abort_i;
    logic                  err_clr_i;
    logic                  im_w_en;
    logic [ADDR_WIDTH-1:0] im_w_addr;
    logic [DATA_WIDTH-1:0] im_w_data;
    logic                  cpu_rst_o;
    logic                  start_o;
    logic                  stop_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [ADDR_WIDTH-1:0] words_loaded_o;

    modport slave (
        input  in_valid, in_byte, abort_i, err_clr_i, stop_i,
        output in_ready, im_w_en, im_w_addr, im_w_data, cpu_rst_o, start_o,
               busy_o, done_o, err_o, words_loaded_o
    );

    modport master (
        output in_valid, in_byte, abort_i, err_clr_i, stop_i,
        input  in_ready, im_w_en, im_w_addr, im_w_data, cpu_rst_o, start_o,
               busy_o, done_o, err_o, words_loaded_o
    );
endinterface

// File: rtl/im_program_loader.sv
// -----------------------------------------------------------------------------
// im_program_loader
// Purpose: receives a program frame [N][hi][lo]...[CHK] over a valid/ready byte
//          stream, writes 16-bit words into IM from address 0, verifies the XOR
//          checksum and then releases and starts the processor, closing the run
//          when the processor raises its stop flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - im_program_loader_if.slave (stream, IM write, processor control,
//          status)
// -----------------------------------------------------------------------------
module im_program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    im_program_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CHK,
        S_START,
        S_RUN,
        S_ERR
    } state_t;

    state_t                r_state;
    logic [BYTE_WIDTH-1:0] r_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BYTE_WIDTH-1:0] r_csum;
    logic [BYTE_WIDTH-1:0] r_hi;
    logic                  r_im_w_en;
    logic [ADDR_WIDTH-1:0] r_im_w_addr;
    logic [DATA_WIDTH-1:0] r_im_w_data;
    logic                  r_cpu_rst;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_words;

    logic                  w_hs;
    logic                  w_last;

    // Moore ready: the loader takes bytes only while waiting for frame content
    assign bus.in_ready = (r_state inside {S_IDLE, S_HI, S_LO, S_CHK});
    assign w_hs         = bus.in_valid & bus.in_ready;
    assign w_last       = (BYTE_WIDTH'(r_addr) == (r_n - BYTE_WIDTH'(1)));

    // Loader FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_addr      <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
            r_im_w_en   <= 1'b0;
            r_im_w_addr <= '0;
            r_im_w_data <= '0;
            r_cpu_rst   <= 1'b1;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            // Pulse outputs default low every cycle
            r_im_w_en <= 1'b0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;

            // Abort wins over everything; also swallows a same-cycle LO write
            if (bus.abort_i && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_cpu_rst <= 1'b1;
                r_err     <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // A zero-length header is consumed and dropped
                        if (w_hs && (bus.in_byte != '0)) begin
                            r_n     <= bus.in_byte;
                            r_addr  <= '0;
                            r_csum  <= '0;
                            r_words <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (w_hs) begin
                            r_hi    <= bus.in_byte;
                            r_csum  <= r_csum ^ bus.in_byte;
                            r_state <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (w_hs) begin
                            r_csum      <= r_csum ^ bus.in_byte;
                            r_im_w_en   <= 1'b1;
                            r_im_w_addr <= r_addr;
                            r_im_w_data <= DATA_WIDTH'({r_hi, bus.in_byte});
                            r_words     <= ADDR_WIDTH'(r_addr + ADDR_WIDTH'(1));
                            if (w_last) begin
                                r_state <= S_CHK;
                            end else begin
                                r_addr  <= ADDR_WIDTH'(r_addr + ADDR_WIDTH'(1));
                                r_state <= S_HI;
                            end
                        end
                    end
                    S_CHK: begin
                        if (w_hs) begin
                            if (bus.in_byte == r_csum) begin
                                r_state <= S_START;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end
                        end
                    end
                    S_START: begin
                        r_cpu_rst <= 1'b0;
                        r_start   <= 1'b1;
                        r_state   <= S_RUN;
                    end
                    S_RUN: begin
                        // stop_i is only meaningful once the processor runs
                        if (bus.stop_i) begin
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_ERR: begin
                        r_cpu_rst <= 1'b1;
                        if (bus.err_clr_i) begin
                            r_err   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.im_w_en        = r_im_w_en;
    assign bus.im_w_addr      = r_im_w_addr;
    assign bus.im_w_data      = r_im_w_data;
    assign bus.cpu_rst_o      = r_cpu_rst;
    assign bus.start_o        = r_start;
    assign bus.busy_o         = r_busy;
    assign bus.done_o         = r_done;
    assign bus.err_o          = r_err;
    assign bus.words_loaded_o = r_words;

endmodule

// File: tb/tb_im_program_loader.sv
// -----------------------------------------------------------------------------
// tb_im_program_loader
// Purpose: self-checking bench for im_program_loader. Expected IM writes are
//          queued as frame bytes are driven and popped by a write monitor.
// -----------------------------------------------------------------------------
module tb_im_program_loader;

    logic clk;
    logic rst;

    im_program_loader_if bus ();

    im_program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned start_cnt = 0;
    int unsigned done_cnt  = 0;

    logic [23:0] exp_q[$];   // {addr, data} of each expected IM write
    logic [15:0] words_q[$]; // program words of the frame being sent

    // Write monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (bus.im_w_en) begin
                logic [23:0] e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL im_write_unexpected: got addr=%02h data=%04h, expected no write",
                             bus.im_w_addr, bus.im_w_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.im_w_addr, bus.im_w_data} !== e) begin
                        n_fail++;
                        $display("FAIL im_write: got addr=%02h data=%04h, expected addr=%02h data=%04h",
                                 bus.im_w_addr, bus.im_w_data, e[23:16], e[15:0]);
                    end
                end
            end
            if (bus.start_o) start_cnt++;
            if (bus.done_o)  done_cnt++;
        end
    end

    // Drive one byte starting at a falling edge; returns at the falling edge
    // right after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        t = 0;
        while ((bus.in_ready !== 1'b1) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 50 cycles", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Send [N][hi lo]*N[CHK] from words_q, queueing the expected writes
    task automatic send_frame(input int n, input bit bad_chk, input bit gaps);
        logic [7:0] cs;
        logic [15:0] w;
        cs = 8'h00;
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            cs = cs ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], gaps);
            exp_q.push_back({8'(i), w});
            send_byte(w[7:0], gaps);
            n_checks++;
            if ((bus.im_w_en !== 1'b1) || (bus.words_loaded_o !== 8'(i + 1))) begin
                n_fail++;
                $display("FAIL write_latency: got im_w_en=%b words_loaded=%0d, expected 1 and %0d",
                         bus.im_w_en, bus.words_loaded_o, i + 1);
            end
        end
        send_byte(bad_chk ? (cs ^ 8'h01) : cs, gaps);
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while ((bus.start_o !== 1'b1) && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_timeout: got start_o=%b, expected 1 within 20 cycles", bus.start_o);
        end
    endtask

    // Let the processor run briefly, stop it, and check the run closes cleanly
    task automatic run_and_stop(input int unsigned start0, input int unsigned done0);
        wait_start();
        n_checks++;
        if ((bus.cpu_rst_o !== 1'b0) || (bus.busy_o !== 1'b1)) begin
            n_fail++;
            $display("FAIL run_entry: got cpu_rst_o=%b busy_o=%b, expected 0 and 1", bus.cpu_rst_o, bus.busy_o);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ((bus.start_o !== 1'b0) || (bus.cpu_rst_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL run_hold: got start_o=%b cpu_rst_o=%b, expected 0 and 0", bus.start_o, bus.cpu_rst_o);
        end
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
        n_checks++;
        if ((bus.done_o !== 1'b1) || (bus.cpu_rst_o !== 1'b1) || (bus.busy_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL run_stop: got done_o=%b cpu_rst_o=%b busy_o=%b, expected 1 1 0",
                     bus.done_o, bus.cpu_rst_o, bus.busy_o);
        end
        @(negedge clk);
        n_checks++;
        if ((bus.done_o !== 1'b0) || (start_cnt != start0 + 1) || (done_cnt != done0 + 1) || (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL run_pulses: got done_o=%b starts=%0d dones=%0d pending=%0d, expected 0 %0d %0d 0",
                     bus.done_o, start_cnt - start0, done_cnt - done0, exp_q.size(), 1, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.abort_i = 1'b0;
        bus.err_clr_i = 1'b0; bus.stop_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.cpu_rst_o, bus.in_ready, bus.im_w_en, bus.start_o, bus.busy_o, bus.done_o, bus.err_o} !== 7'b1100000
            || bus.words_loaded_o !== 8'h00 || bus.im_w_addr !== 8'h00 || bus.im_w_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got rst/rdy/wen/start/busy/done/err=%b words=%0d addr=%h data=%h, expected 1100000 0 00 0000",
                     {bus.cpu_rst_o, bus.in_ready, bus.im_w_en, bus.start_o, bus.busy_o, bus.done_o, bus.err_o},
                     bus.words_loaded_o, bus.im_w_addr, bus.im_w_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_run();
        int unsigned s0, d0;
        s0 = start_cnt; d0 = done_cnt;
        words_q = '{16'h1234, 16'hABCD};
        send_frame(2, 1'b0, 1'b0);
        run_and_stop(s0, d0);
        n_checks++;
        if (bus.words_loaded_o !== 8'd2) begin
            n_fail++;
            $display("FAIL basic_words: got %0d, expected 2", bus.words_loaded_o);
        end
    endtask

    task automatic test_bad_checksum();
        int unsigned s0;
        s0 = start_cnt;
        words_q = '{16'h1234, 16'hABCD};
        send_frame(2, 1'b1, 1'b0);
        n_checks++;
        if ((bus.err_o !== 1'b1) || (bus.cpu_rst_o !== 1'b1) || (bus.busy_o !== 1'b1) || (bus.in_ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL err_entry: got err_o=%b cpu_rst_o=%b busy_o=%b in_ready=%b, expected 1 1 1 0",
                     bus.err_o, bus.cpu_rst_o, bus.busy_o, bus.in_ready);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if ((bus.err_o !== 1'b1) || (start_cnt != s0) || (bus.cpu_rst_o !== 1'b1) || (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL err_hold: got err_o=%b starts=%0d cpu_rst_o=%b pending=%0d, expected 1 0 1 0",
                     bus.err_o, start_cnt - s0, bus.cpu_rst_o, exp_q.size());
        end
        bus.err_clr_i = 1'b1;
        @(negedge clk);
        bus.err_clr_i = 1'b0;
        n_checks++;
        if ((bus.err_o !== 1'b0) || (bus.busy_o !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            n_fail++;
            $display("FAIL err_clear: got err_o=%b busy_o=%b in_ready=%b, expected 0 0 1",
                     bus.err_o, bus.busy_o, bus.in_ready);
        end
    endtask

    task automatic test_zero_header();
        int unsigned s0, d0;
        s0 = start_cnt; d0 = done_cnt;
        send_byte(8'h00, 1'b0);
        n_checks++;
        if ((bus.busy_o !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            n_fail++;
            $display("FAIL zero_header: got busy_o=%b in_ready=%b, expected 0 1", bus.busy_o, bus.in_ready);
        end
        words_q = '{16'hF000};
        send_frame(1, 1'b0, 1'b0);
        run_and_stop(s0, d0);
    endtask

    task automatic test_max_gapped();
        int unsigned s0, d0;
        s0 = start_cnt; d0 = done_cnt;
        words_q.delete();
        for (int i = 0; i < 255; i++) words_q.push_back(16'($urandom));
        send_frame(255, 1'b0, 1'b1);
        n_checks++;
        if ((bus.words_loaded_o !== 8'd255) || (bus.err_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL max_words: got words_loaded=%0d err_o=%b, expected 255 0", bus.words_loaded_o, bus.err_o);
        end
        run_and_stop(s0, d0);
    endtask

    task automatic test_abort();
        int unsigned d0;
        d0 = done_cnt;
        words_q.delete();
        for (int i = 0; i < 8; i++) words_q.push_back(16'(16'h1100 * (i + 1) + i));
        send_byte(8'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(words_q[i][15:8], 1'b0);
            exp_q.push_back({8'(i), words_q[i]});
            send_byte(words_q[i][7:0], 1'b0);
        end
        send_byte(words_q[3][15:8], 1'b0);
        bus.abort_i = 1'b1;
        send_byte(words_q[3][7:0], 1'b0);
        bus.abort_i = 1'b0;
        n_checks++;
        if ((bus.im_w_en !== 1'b0) || (bus.busy_o !== 1'b0) || (bus.cpu_rst_o !== 1'b1) || (bus.im_w_addr !== 8'd2)) begin
            n_fail++;
            $display("FAIL abort_state: got im_w_en=%b busy_o=%b cpu_rst_o=%b im_w_addr=%0d, expected 0 0 1 2",
                     bus.im_w_en, bus.busy_o, bus.cpu_rst_o, bus.im_w_addr);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ((done_cnt != d0) || (exp_q.size() != 0) || (bus.in_ready !== 1'b1)) begin
            n_fail++;
            $display("FAIL abort_after: got dones=%0d pending=%0d in_ready=%b, expected 0 0 1",
                     done_cnt - d0, exp_q.size(), bus.in_ready);
        end
    endtask

    task automatic test_stop_in_start_and_async_reset();
        int unsigned d0;
        d0 = done_cnt;
        words_q = '{16'h5A5A};
        send_frame(1, 1'b0, 1'b0);
        bus.stop_i = 1'b1;   // loader is in START during this cycle
        @(negedge clk);
        bus.stop_i = 1'b0;
        n_checks++;
        if ((bus.start_o !== 1'b1) || (bus.busy_o !== 1'b1) || (bus.cpu_rst_o !== 1'b0) || (bus.done_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL stop_in_start: got start_o=%b busy_o=%b cpu_rst_o=%b done_o=%b, expected 1 1 0 0",
                     bus.start_o, bus.busy_o, bus.cpu_rst_o, bus.done_o);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ((bus.busy_o !== 1'b1) || (done_cnt != d0)) begin
            n_fail++;
            $display("FAIL still_running: got busy_o=%b dones=%0d, expected 1 0", bus.busy_o, done_cnt - d0);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ((bus.cpu_rst_o !== 1'b1) || (bus.busy_o !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            n_fail++;
            $display("FAIL async_reset: got cpu_rst_o=%b busy_o=%b in_ready=%b, expected 1 0 1",
                     bus.cpu_rst_o, bus.busy_o, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion within 2 ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_run();
        test_bad_checksum();
        test_zero_header();
        test_max_gapped();
        test_abort();
        test_stop_in_start_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
